jtag_mailbox: RTL and testbench

JTAG_MAILBOX -- requirements
Module: jtag_mailbox

---
 rtl/jtag_mailbox.sv | 139 +++++++++++++
 tb/tb_jtag_mailbox.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_mailbox.sv
// Bridges a JTAG-register command/status pair onto a valid/ready bus, one transfer per new tag.
// Optional bus wait limit enabled by defining JTAG_MAILBOX_TIMEOUT_EN.
module jtag_mailbox #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  iMAIN_CLK,
  input  logic                  iRESET,
  input  logic [ADDR_WIDTH+8:0] iCMD,
  input  logic [DATA_WIDTH-1:0] iWDATA,
  output logic [15:0]           oSTATUS,
  output logic [DATA_WIDTH-1:0] oRDATA,
  output logic                  oBUS_VALID,
  input  logic                  iBUS_READY,
  output logic                  oBUS_WE,
  output logic [ADDR_WIDTH-1:0] oBUS_ADDR,
  output logic [DATA_WIDTH-1:0] oBUS_WDATA,
  input  logic [DATA_WIDTH-1:0] iBUS_RDATA
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH+8:0] cmd_q;
  logic                  vld_q, vld_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            tag_q, tag_d;
  logic [7:0]            done_tag_q, done_tag_d;
  logic                  error;
  logic                  new_cmd;
  logic                  xfer_done;
  logic                  timeout;

  // A command counts only once it has been stable for a full cycle, so a
  // JTAG update that lands mid-shift is never half-sampled.
  assign new_cmd   = (state_q == IDLE) && (iCMD == cmd_q)
                     && (iCMD[ADDR_WIDTH+8 -: 8] != done_tag_q);
  assign xfer_done = (state_q == REQ) && iBUS_READY;

`ifdef JTAG_MAILBOX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;

  assign timeout = (state_q == REQ) && !iBUS_READY
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign error   = error_q;

  always_comb begin
    cnt_d   = '0;
    error_d = error_q;
    if (state_q == REQ && !iBUS_READY && !timeout) cnt_d = cnt_q + 1'b1;
    if (xfer_done) error_d = 1'b0;
    if (timeout)   error_d = 1'b1;
  end

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_cmd) state_d = REQ;
      REQ:     if (xfer_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d      = (state_d == REQ);
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tag_d      = tag_q;
    done_tag_d = done_tag_q;
    if (new_cmd) begin
      we_d    = iCMD[ADDR_WIDTH];
      addr_d  = iCMD[ADDR_WIDTH-1:0];
      wdata_d = iWDATA;
      tag_d   = iCMD[ADDR_WIDTH+8 -: 8];
    end
    if (xfer_done) begin
      done_tag_d = tag_q;
      if (!we_q) rdata_d = iBUS_RDATA;
    end
    if (timeout) done_tag_d = tag_q;
  end

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      cmd_q      <= '0;
      vld_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tag_q      <= '0;
      done_tag_q <= '0;
    end else begin
      cmd_q      <= iCMD;
      vld_q      <= vld_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tag_q      <= tag_d;
      done_tag_q <= done_tag_d;
    end
  end

  assign oSTATUS    = {done_tag_q, 6'b0, error, state_q == REQ};
  assign oRDATA     = rdata_q;
  assign oBUS_VALID = vld_q;
  assign oBUS_WE    = we_q;
  assign oBUS_ADDR  = addr_q;
  assign oBUS_WDATA = wdata_q;

endmodule

// File: tb/tb_jtag_mailbox.sv
// Directed bench for jtag_mailbox: transaction-level reference model checked every cycle
// plus literal end-of-scenario expectations.
module tb_jtag_mailbox;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW+8:0] cmd;
  logic [DW-1:0] wdata;
  logic [15:0]   status;
  logic [DW-1:0] rdata;
  logic          bvld;
  logic          brdy;
  logic          bwe;
  logic [AW-1:0] baddr;
  logic [DW-1:0] bwdata;
  logic [DW-1:0] brdata;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  bit started = 1'b0;

  jtag_mailbox #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .iMAIN_CLK (clk),
    .iRESET    (rst),
    .iCMD      (cmd),
    .iWDATA    (wdata),
    .oSTATUS   (status),
    .oRDATA    (rdata),
    .oBUS_VALID(bvld),
    .iBUS_READY(brdy),
    .oBUS_WE   (bwe),
    .oBUS_ADDR (baddr),
    .oBUS_WDATA(bwdata),
    .iBUS_RDATA(brdata)
  );

  always #5 clk = ~clk;

  // Reference model: a pending transfer is either outstanding or not.
  bit            m_pending;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic [7:0]    m_tag;
  logic [7:0]    m_done;
  bit            m_err;
  logic [AW+8:0] m_last_cmd;
  int            m_waited;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_pending = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_tag = '0; m_done = '0; m_err = 0; m_last_cmd = '0; m_waited = 0;
    end else begin
      if (m_pending) begin
        if (brdy) begin
          m_pending = 0; m_done = m_tag; m_err = 0;
          if (!m_we) m_rdata = brdata;
        end else begin
`ifdef JTAG_MAILBOX_TIMEOUT_EN
          if (m_waited == TO - 1) begin
            m_pending = 0; m_done = m_tag; m_err = 1;
          end else m_waited++;
`endif
        end
      end else if (cmd == m_last_cmd && cmd[AW+8 -: 8] != m_done) begin
        m_pending = 1; m_waited = 0;
        m_tag = cmd[AW+8 -: 8]; m_we = cmd[AW]; m_addr = cmd[AW-1:0]; m_wdata = wdata;
      end
      m_last_cmd = cmd;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("valid", 64'(bvld), 64'(m_pending));
      check("status", 64'(status), 64'({m_done, 6'b0, m_err, m_pending}));
      check("rdata", 64'(rdata), 64'(m_rdata));
      if (m_pending) begin
        check("bus_we", 64'(bwe), 64'(m_we));
        check("bus_addr", 64'(baddr), 64'(m_addr));
        check("bus_wdata", 64'(bwdata), 64'(m_wdata));
      end
      if (bvld) vcnt++;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW+8:0] mk(input logic [7:0] tag, input logic we, input logic [AW-1:0] a);
    return {tag, we, a};
  endfunction

  initial begin
    rst = 1'b1; cmd = '0; wdata = '0; brdy = 1'b0; brdata = '0;
    step(2);
    check("reset_status", 64'(status), 64'h0);
    check("reset_valid", 64'(bvld), 64'h0);
    check("reset_rdata", 64'(rdata), 64'h0);

    // write, ready tied high
    rst = 1'b0; brdy = 1'b1; wdata = 32'hDEADBEEF; cmd = mk(8'h01, 1'b1, 16'h0010);
    vcnt = 0;
    step(2);
    check("wr_valid_cycle2", 64'(bvld), 64'h1);
    check("wr_we", 64'(bwe), 64'h1);
    check("wr_addr", 64'(baddr), 64'h0010);
    step(4);
    check("wr_vcnt", 64'(vcnt), 64'd1);
    check("wr_status", 64'(status), 64'h0100);

    // read, ready 5 cycles late
    brdy = 1'b0; brdata = 32'h12345678; cmd = mk(8'h02, 1'b0, 16'h0020); vcnt = 0;
    step(7);
    brdy = 1'b1;
    step(1);
    brdy = 1'b0;
    step(3);
    check("rd_vcnt", 64'(vcnt), 64'd6);
    check("rd_rdata", 64'(rdata), 64'h12345678);
    check("rd_status", 64'(status), 64'h0200);

    // same tag ignored; FF then 00 both issue
    brdy = 1'b1; cmd = mk(8'h02, 1'b1, 16'h0030); vcnt = 0;
    step(5);
    check("dup_vcnt", 64'(vcnt), 64'd0);
    cmd = mk(8'hFF, 1'b1, 16'h0040); vcnt = 0;
    step(5);
    check("ff_vcnt", 64'(vcnt), 64'd1);
    check("ff_status", 64'(status), 64'hFF00);
    cmd = mk(8'h00, 1'b1, 16'h0050); vcnt = 0;
    step(5);
    check("wrap_vcnt", 64'(vcnt), 64'd1);
    check("wrap_status", 64'(status), 64'h0000);

    // command change during REQ is deferred
    brdy = 1'b0; cmd = mk(8'h03, 1'b0, 16'h0060); vcnt = 0;
    step(3);
    check("chg_addr03", 64'(baddr), 64'h0060);
    cmd = mk(8'h04, 1'b1, 16'h0070);
    step(3);
    check("chg_still03", 64'(baddr), 64'h0060);
    brdy = 1'b1;
    step(5);
    check("chg_vcnt", 64'(vcnt), 64'd6);
    check("chg_status", 64'(status), 64'h0400);

    // command changing every cycle only triggers once stable
    vcnt = 0;
    cmd = mk(8'h10, 1'b1, 16'h0100); step(1);
    cmd = mk(8'h11, 1'b1, 16'h0110); step(1);
    cmd = mk(8'h12, 1'b1, 16'h0120); step(5);
    check("unstable_vcnt", 64'(vcnt), 64'd1);
    check("unstable_status", 64'(status), 64'h1200);

    // reset during REQ
    brdy = 1'b0; cmd = mk(8'h06, 1'b1, 16'h0080);
    step(4);
    check("pre_rst_valid", 64'(bvld), 64'h1);
    rst = 1'b1;
    step(1);
    check("rst_valid", 64'(bvld), 64'h0);
    check("rst_status", 64'(status), 64'h0);
    rst = 1'b0; brdy = 1'b1;
    step(5);
    check("post_rst_status", 64'(status), 64'h0600);

    brdy = 1'b0; cmd = mk(8'h05, 1'b1, 16'h0090); vcnt = 0;
    step(14);
`ifdef JTAG_MAILBOX_TIMEOUT_EN
    check("to_vcnt", 64'(vcnt), 64'd8);
    check("to_status", 64'(status), 64'h0502);
`else
    check("wait_vcnt", 64'(vcnt), 64'd12);
    check("wait_status", 64'(status), 64'h0601);
    brdy = 1'b1;
    step(3);
    check("wait_done", 64'(status), 64'h0500);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
